// File: rtl/uart_pkg.sv
// Shared FSM state types, frame constants and baud-divider helper for uart_txrx.
// Used by uart_txrx and uart_bit_timer via import uart_pkg::*.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_DONE
    } txState_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CLEANUP
    } rxState_e;

    // Integer division: the bit period is truncated, never rounded up.
    function automatic int clks_per_bit(input int sys_clock, input int baud);
        return sys_clock / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: tick_o marks the end of a full bit period, or the
// half-bit point when half_i is set. Reloads on clear_i and on every tick.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    // Reached after CLKS_PER_BIT/2 cycles counted down from FULL_LOAD.
    localparam logic [CW-1:0] HALF_MARK = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        tick_o  = half_i ? (count_q == HALF_MARK) : (count_q == '0);
        count_d = count_q - CW'(1);
        if (clear_i || tick_o) begin
            count_d = FULL_LOAD;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= FULL_LOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx: full-duplex 8N1 UART with independent TX/RX FSMs and an RX synchronizer.
// Optional: define UART_FRAME_ERR_EN to add o_RxFrameErr (sampled stop bit was 0).
module uart_txrx
    import uart_pkg::*;
#(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200
) (
    input  logic       i_SysClock,
    input  logic       i_Reset,
    input  logic       i_TxValid,
    input  logic [7:0] i_TxByte,
    output logic       o_TxSerial,
    output logic       o_TxDone,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxDone
`ifdef UART_FRAME_ERR_EN
    ,
    output logic       o_RxFrameErr
`endif
);

    localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLOCK, UART_BAUDRATE);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    txState_e   txState_q, txState_d;
    logic [7:0] txShift_q, txShift_d;
    logic [2:0] txBitCnt_q, txBitCnt_d;
    logic       txSerial_q, txSerial_d;
    logic       txTick;

    rxState_e   rxState_q, rxState_d;
    logic       rxSync1_q, rxSync2_q;
    logic [7:0] rxShift_q, rxShift_d;
    logic [2:0] rxBitCnt_q, rxBitCnt_d;
    logic [7:0] rxByte_q, rxByte_d;
    logic       rxDone_q, rxDone_d;
    logic       rxTick;
`ifdef UART_FRAME_ERR_EN
    logic       stopBit_q, stopBit_d;
    logic       frameErr_q, frameErr_d;
`endif

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_txTimer (
        .clock_i (i_SysClock),
        .reset_i (i_Reset),
        .clear_i (txState_q == TX_IDLE),
        .half_i  (1'b0),
        .tick_o  (txTick)
    );

    // START and CLEANUP time half a bit; the START half-tick recentres sampling mid-bit.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rxTimer (
        .clock_i (i_SysClock),
        .reset_i (i_Reset),
        .clear_i (rxState_q == RX_IDLE),
        .half_i  ((rxState_q == RX_START) || (rxState_q == RX_CLEANUP)),
        .tick_o  (rxTick)
    );

    always_comb begin
        txState_d  = txState_q;
        txShift_d  = txShift_q;
        txBitCnt_d = txBitCnt_q;
        case (txState_q)
            TX_IDLE: begin
                if (i_TxValid) begin
                    txShift_d  = i_TxByte;
                    txBitCnt_d = '0;
                    txState_d  = TX_START;
                end
            end
            TX_START: begin
                if (txTick) txState_d = TX_DATA;
            end
            TX_DATA: begin
                if (txTick) begin
                    txShift_d  = {1'b1, txShift_q[7:1]};
                    txBitCnt_d = txBitCnt_q + 3'd1;
                    if (txBitCnt_q == LAST_DATA) begin
                        txBitCnt_d = '0;
                        txState_d  = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (txTick) begin
                    txBitCnt_d = txBitCnt_q + 3'd1;
                    if (txBitCnt_q == LAST_STOP) begin
                        txBitCnt_d = '0;
                        txState_d  = TX_DONE;
                    end
                end
            end
            TX_DONE:  txState_d = TX_IDLE;
            default:  txState_d = TX_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        txSerial_d = 1'b1;
        case (txState_d)
            TX_START: txSerial_d = 1'b0;
            TX_DATA:  txSerial_d = txShift_d[0];
            default:  txSerial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            txState_q  <= TX_IDLE;
            txShift_q  <= '0;
            txBitCnt_q <= '0;
            txSerial_q <= 1'b1;
        end else begin
            txState_q  <= txState_d;
            txShift_q  <= txShift_d;
            txBitCnt_q <= txBitCnt_d;
            txSerial_q <= txSerial_d;
        end
    end

    assign o_TxSerial = txSerial_q;
    assign o_TxDone   = (txState_q == TX_DONE);

    always_comb begin
        rxState_d  = rxState_q;
        rxShift_d  = rxShift_q;
        rxBitCnt_d = rxBitCnt_q;
        rxByte_d   = rxByte_q;
        rxDone_d   = 1'b0;
`ifdef UART_FRAME_ERR_EN
        stopBit_d  = stopBit_q;
        frameErr_d = frameErr_q;
`endif
        case (rxState_q)
            RX_IDLE: begin
                if (!rxSync2_q) rxState_d = RX_START;
            end
            RX_START: begin
                if (rxTick) begin
                    if (!rxSync2_q) begin
                        rxBitCnt_d = '0;
                        rxState_d  = RX_DATA;
                    end else begin
                        rxState_d  = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rxTick) begin
                    rxShift_d  = {rxSync2_q, rxShift_q[7:1]};
                    rxBitCnt_d = rxBitCnt_q + 3'd1;
                    if (rxBitCnt_q == LAST_DATA) begin
                        rxBitCnt_d = '0;
                        rxState_d  = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rxTick) begin
`ifdef UART_FRAME_ERR_EN
                    stopBit_d = rxSync2_q;
`endif
                    rxState_d = RX_CLEANUP;
                end
            end
            RX_CLEANUP: begin
                if (rxTick) begin
                    rxByte_d  = rxShift_q;
                    rxDone_d  = 1'b1;
`ifdef UART_FRAME_ERR_EN
                    frameErr_d = ~stopBit_q;
`endif
                    rxState_d = RX_IDLE;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // Two-flop synchronizer resets to the idle (high) line level.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            rxSync1_q  <= 1'b1;
            rxSync2_q  <= 1'b1;
            rxState_q  <= RX_IDLE;
            rxShift_q  <= '0;
            rxBitCnt_q <= '0;
            rxByte_q   <= '0;
            rxDone_q   <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            stopBit_q  <= 1'b1;
            frameErr_q <= 1'b0;
`endif
        end else begin
            rxSync1_q  <= i_RxSerial;
            rxSync2_q  <= rxSync1_q;
            rxState_q  <= rxState_d;
            rxShift_q  <= rxShift_d;
            rxBitCnt_q <= rxBitCnt_d;
            rxByte_q   <= rxByte_d;
            rxDone_q   <= rxDone_d;
`ifdef UART_FRAME_ERR_EN
            stopBit_q  <= stopBit_d;
            frameErr_q <= frameErr_d;
`endif
        end
    end

    assign o_RxByte = rxByte_q;
    assign o_RxDone = rxDone_q;
`ifdef UART_FRAME_ERR_EN
    assign o_RxFrameErr = frameErr_q;
`endif

endmodule

// File: tb/tb_uart_txrx.sv
// Directed self-checking bench for uart_txrx: loopback frames plus a bench-driven RX line.
// Define UART_FRAME_ERR_EN to also check o_RxFrameErr.
module tb_uart_txrx;

    localparam int N = 434;   // 50 MHz / 115200, integer division

    logic       clock = 1'b0;
    logic       reset;
    logic       txValid;
    logic [7:0] txByte;
    logic       txSerial;
    logic       txDone;
    logic [7:0] rxByte;
    logic       rxDone;
    logic       loopback;
    logic       tbRx;
    logic       rxLine;
`ifdef UART_FRAME_ERR_EN
    logic       rxFrameErr;
`endif

    int checks   = 0;
    int failures = 0;

    always #10 clock = ~clock;

    assign rxLine = loopback ? txSerial : tbRx;

    uart_txrx dut (
        .i_SysClock (clock),
        .i_Reset    (reset),
        .i_TxValid  (txValid),
        .i_TxByte   (txByte),
        .o_TxSerial (txSerial),
        .o_TxDone   (txDone),
        .i_RxSerial (rxLine),
        .o_RxByte   (rxByte),
        .o_RxDone   (rxDone)
`ifdef UART_FRAME_ERR_EN
        ,
        .o_RxFrameErr (rxFrameErr)
`endif
    );

    // Sends one loopback frame and records negedge indices of the key events.
    task automatic runFrame(input logic [7:0] b, input int hold,
                            output int fallIdx, output int txDoneIdx, output int rxDoneIdx,
                            output int txDoneCnt, output int rxDoneCnt, output logic [7:0] got);
        int stopAt;
        fallIdx = -1; txDoneIdx = -1; rxDoneIdx = -1;
        txDoneCnt = 0; rxDoneCnt = 0; got = 8'h00;
        stopAt = 11 * N;
        txByte  = b;
        txValid = 1'b1;
        for (int i = 1; i <= stopAt; i++) begin
            @(negedge clock);
            if (i >= hold) txValid = 1'b0;
            if (fallIdx < 0 && txSerial === 1'b0) fallIdx = i;
            if (txDone === 1'b1) begin
                txDoneCnt++;
                if (txDoneIdx < 0) txDoneIdx = i;
            end
            if (rxDone === 1'b1) begin
                rxDoneCnt++;
                if (rxDoneIdx < 0) begin
                    rxDoneIdx = i;
                    got = rxByte;
                    stopAt = i + 2;
                end
            end
        end
        txValid = 1'b0;
    endtask

    // Bit-bangs a frame onto the RX pin with a chosen stop-bit level.
    task automatic driveRxFrame(input logic [7:0] b, input logic stopBit,
                                output int doneCnt, output logic [7:0] got);
        logic [9:0] frame;
        frame   = {stopBit, b, 1'b0};
        doneCnt = 0;
        got     = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tbRx = frame[k];
            for (int c = 0; c < N; c++) begin
                @(negedge clock);
                if (rxDone === 1'b1) begin doneCnt++; got = rxByte; end
            end
        end
        tbRx = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (rxDone === 1'b1) begin doneCnt++; got = rxByte; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; txValid = 1'b0; txByte = 8'h00; loopback = 1'b1; tbRx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (txSerial !== 1'b1) begin failures++; $display("[TB] FAIL reset_txSerial: got %b expected 1", txSerial); end
        checks++; if (txDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_txDone: got %b expected 0", txDone); end
        checks++; if (rxByte !== 8'h00) begin failures++; $display("[TB] FAIL reset_rxByte: got %h expected 00", rxByte); end
        checks++; if (rxDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_rxDone: got %b expected 0", rxDone); end
    endtask

    task automatic test_single_frame();
        int fallIdx, txDoneIdx, rxDoneIdx, txDoneCnt, rxDoneCnt, lowCnt;
        logic [7:0] got;
        loopback = 1'b1;
        runFrame(8'h55, 2, fallIdx, txDoneIdx, rxDoneIdx, txDoneCnt, rxDoneCnt, got);
        checks++; if (fallIdx !== 1) begin failures++; $display("[TB] FAIL single_startLatency: got %0d expected 1", fallIdx); end
        checks++; if (txDoneIdx - fallIdx < 10*N-1 || txDoneIdx - fallIdx > 10*N+1) begin
            failures++; $display("[TB] FAIL single_frameLength: got %0d expected %0d", txDoneIdx - fallIdx, 10*N); end
        checks++; if (txDoneCnt !== 1) begin failures++; $display("[TB] FAIL single_txDoneCount: got %0d expected 1", txDoneCnt); end
        checks++; if (rxDoneCnt !== 1) begin failures++; $display("[TB] FAIL single_rxDoneCount: got %0d expected 1", rxDoneCnt); end
        checks++; if (rxDoneIdx - txDoneIdx < 2 || rxDoneIdx - txDoneIdx > 4 || txDoneIdx < 0) begin
            failures++; $display("[TB] FAIL single_rxAfterTx: got %0d expected 2..4", rxDoneIdx - txDoneIdx); end
        checks++; if (got !== 8'h55) begin failures++; $display("[TB] FAIL single_rxByte: got %h expected 55", got); end
        lowCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (txSerial !== 1'b1) lowCnt++;
        end
        checks++; if (lowCnt !== 0) begin failures++; $display("[TB] FAIL single_oneFrameOnly: got %0d low cycles expected 0", lowCnt); end
    endtask

    task automatic test_sequential();
        logic [7:0] seqBytes [3] = '{8'hAA, 8'hFF, 8'hAA};
        int fallIdx, txDoneIdx, rxDoneIdx, txDoneCnt, rxDoneCnt;
        logic [7:0] got;
        loopback = 1'b1;
        for (int s = 0; s < 3; s++) begin
            runFrame(seqBytes[s], 1, fallIdx, txDoneIdx, rxDoneIdx, txDoneCnt, rxDoneCnt, got);
            checks++; if (got !== seqBytes[s]) begin
                failures++; $display("[TB] FAIL seq_rxByte[%0d]: got %h expected %h", s, got, seqBytes[s]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [10];
        int sent, recv, fallIdx, lastDoneIdx, validLeft;
        bit inFrame;
        logic prevTx;
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom_range(0, 255));
        loopback = 1'b1;
        sent = 1; recv = 0; fallIdx = -1; lastDoneIdx = -1; inFrame = 1'b0; prevTx = txSerial;
        txByte = bytes[0]; txValid = 1'b1; validLeft = 1;
        for (int cyc = 1; cyc <= 10 * (10*N + 10) && recv < 10; cyc++) begin
            @(negedge clock);
            if (validLeft > 0) begin
                validLeft--;
                if (validLeft == 0) txValid = 1'b0;
            end
            if (!inFrame && prevTx === 1'b1 && txSerial === 1'b0) begin
                inFrame = 1'b1;
                fallIdx = cyc;
                if (lastDoneIdx > 0) begin
                    checks++; if (cyc - lastDoneIdx !== 2) begin
                        failures++; $display("[TB] FAIL b2b_restartGap: got %0d expected 2", cyc - lastDoneIdx); end
                end
            end
            if (txDone === 1'b1) begin
                checks++; if (!inFrame || cyc - fallIdx < 10*N-1 || cyc - fallIdx > 10*N+1) begin
                    failures++; $display("[TB] FAIL b2b_frameLength: got %0d expected %0d", cyc - fallIdx, 10*N); end
                inFrame = 1'b0;
                lastDoneIdx = cyc;
                if (sent < 10) begin
                    txByte = bytes[sent]; txValid = 1'b1; validLeft = 2; sent++;
                end
            end
            if (rxDone === 1'b1) begin
                checks++; if (rxByte !== bytes[recv]) begin
                    failures++; $display("[TB] FAIL b2b_rxByte[%0d]: got %h expected %h", recv, rxByte, bytes[recv]); end
                recv++;
            end
            prevTx = txSerial;
        end
        txValid = 1'b0;
        checks++; if (recv !== 10) begin failures++; $display("[TB] FAIL b2b_frameCount: got %0d expected 10", recv); end
        repeat (5) @(negedge clock);
    endtask

    task automatic test_glitch();
        int rxCnt, doneCnt;
        logic [7:0] got;
        loopback = 1'b0; tbRx = 1'b1;
        repeat (4) @(negedge clock);
        rxCnt = 0;
        tbRx = 1'b0;
        for (int i = 0; i < 100; i++) begin @(negedge clock); if (rxDone === 1'b1) rxCnt++; end
        tbRx = 1'b1;
        for (int i = 0; i < 2*N; i++) begin @(negedge clock); if (rxDone === 1'b1) rxCnt++; end
        checks++; if (rxCnt !== 0) begin failures++; $display("[TB] FAIL glitch_noRxDone: got %0d expected 0", rxCnt); end
        driveRxFrame(8'h3C, 1'b1, doneCnt, got);
        checks++; if (doneCnt !== 1) begin failures++; $display("[TB] FAIL glitch_nextDoneCount: got %0d expected 1", doneCnt); end
        checks++; if (got !== 8'h3C) begin failures++; $display("[TB] FAIL glitch_nextByte: got %h expected 3c", got); end
`ifdef UART_FRAME_ERR_EN
        checks++; if (rxFrameErr !== 1'b0) begin failures++; $display("[TB] FAIL glitch_frameErr: got %b expected 0", rxFrameErr); end
`endif
    endtask

    task automatic test_reset_mid_tx();
        int txCnt, rxCnt, fallIdx, txDoneIdx, rxDoneIdx, txDoneCnt, rxDoneCnt;
        logic [7:0] got;
        loopback = 1'b1;
        txByte = 8'hC3; txValid = 1'b1;
        @(negedge clock);
        txValid = 1'b0;
        repeat (4*N + N/2 - 1) @(negedge clock);
        checks++; if (txSerial !== 1'b0) begin failures++; $display("[TB] FAIL rst_bit3Level: got %b expected 0", txSerial); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (txSerial !== 1'b1) begin failures++; $display("[TB] FAIL rst_txSerialHigh: got %b expected 1", txSerial); end
        checks++; if (rxByte !== 8'h00) begin failures++; $display("[TB] FAIL rst_rxByteCleared: got %h expected 00", rxByte); end
        txCnt = 0; rxCnt = 0;
        for (int i = 0; i < 6*N; i++) begin
            @(negedge clock);
            if (txDone === 1'b1) txCnt++;
            if (rxDone === 1'b1) rxCnt++;
        end
        checks++; if (txCnt !== 0) begin failures++; $display("[TB] FAIL rst_noTxDone: got %0d expected 0", txCnt); end
        checks++; if (rxCnt !== 0) begin failures++; $display("[TB] FAIL rst_noRxDone: got %0d expected 0", rxCnt); end
        runFrame(8'hA5, 1, fallIdx, txDoneIdx, rxDoneIdx, txDoneCnt, rxDoneCnt, got);
        checks++; if (got !== 8'hA5) begin failures++; $display("[TB] FAIL rst_afterByte: got %h expected a5", got); end
        checks++; if (txDoneCnt !== 1) begin failures++; $display("[TB] FAIL rst_afterTxDone: got %0d expected 1", txDoneCnt); end
    endtask

    task automatic test_frame_error();
        int doneCnt;
        logic [7:0] got;
        loopback = 1'b0; tbRx = 1'b1;
        repeat (4) @(negedge clock);
        driveRxFrame(8'h81, 1'b0, doneCnt, got);
        checks++; if (doneCnt !== 1) begin failures++; $display("[TB] FAIL ferr_doneCount: got %0d expected 1", doneCnt); end
        checks++; if (got !== 8'h81) begin failures++; $display("[TB] FAIL ferr_rxByte: got %h expected 81", got); end
`ifdef UART_FRAME_ERR_EN
        checks++; if (rxFrameErr !== 1'b1) begin failures++; $display("[TB] FAIL ferr_flag: got %b expected 1", rxFrameErr); end
`endif
    endtask

    initial begin
        $display("[TB] uart_txrx directed test start");
        test_reset();
        test_single_frame();
        test_sequential();
        test_back_to_back();
        test_glitch();
        test_reset_mid_tx();
        test_frame_error();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
